// File: rtl/smux_arbiter.sv
// smux_arbiter
//   Two-requester round-robin arbiter that time-shares one signed 2:1 select
//   path and one output register between source A and source B. The winning
//   operand is registered and offered downstream with a valid/ready handshake.
//
//   Optional feature macro: SMUX_ARB_STATS_EN
//     When defined, adds saturating per-source grant counters
//     (grant_a_cnt, grant_b_cnt). When undefined, those ports and the
//     counter logic do not exist.
//
//   Ports
//     Clk          rising-edge clock
//     Rst          asynchronous active-low reset
//     a_data       signed operand from source A
//     a_valid      A offers a_data
//     a_ready      A transfer accepted this cycle
//     b_data       signed operand from source B
//     b_valid      B offers b_data
//     b_ready      B transfer accepted this cycle
//     d            registered selected operand
//     d_valid      d holds an unconsumed operand
//     d_ready      consumer accepts d
//     sel          source of current d (0=A, 1=B)
//     grant_a_cnt  accepted A transfers, saturating (SMUX_ARB_STATS_EN only)
//     grant_b_cnt  accepted B transfers, saturating (SMUX_ARB_STATS_EN only)
module smux_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int CNTWIDTH  = 16
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic signed [DATAWIDTH-1:0] a_data,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic signed [DATAWIDTH-1:0] b_data,
    input  logic                        b_valid,
    output logic                        b_ready,
    output logic signed [DATAWIDTH-1:0] d,
    output logic                        d_valid,
    input  logic                        d_ready,
`ifdef SMUX_ARB_STATS_EN
    output logic        [CNTWIDTH-1:0]  grant_a_cnt,
    output logic        [CNTWIDTH-1:0]  grant_b_cnt,
`endif
    output logic                        sel
);

    logic signed [DATAWIDTH-1:0] d_p1;
    logic                        vld_p1;
    logic                        sel_p1;
    logic                        last_p1;   // source of most recent input transfer

    logic grant_a;
    logic grant_b;
    logic load_en;
    logic a_xfer;
    logic b_xfer;

    // ---- stage 0: arbitration and handshake (combinational) ----
    // On a tie the source that did not win last time gets the grant, so
    // last_p1=1 after reset hands the first tie to A.
    assign grant_a = a_valid && (!b_valid || last_p1);
    assign grant_b = b_valid && (!a_valid || !last_p1);
    assign load_en = !vld_p1 || d_ready;
    assign a_ready = load_en && grant_a;
    assign b_ready = load_en && grant_b;
    assign a_xfer  = a_valid && a_ready;
    assign b_xfer  = b_valid && b_ready;

    // ---- stage 1: output register ----
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            d_p1    <= '0;
            vld_p1  <= 1'b0;
            sel_p1  <= 1'b0;
            last_p1 <= 1'b1;
        end else if (a_xfer || b_xfer) begin
            d_p1    <= b_xfer ? b_data : a_data;
            vld_p1  <= 1'b1;
            sel_p1  <= b_xfer;
            last_p1 <= b_xfer;
        end else if (d_ready) begin
            // Drained with nothing new: d and sel keep their last values.
            vld_p1  <= 1'b0;
        end
    end

    assign d       = d_p1;
    assign d_valid = vld_p1;
    assign sel     = sel_p1;

`ifdef SMUX_ARB_STATS_EN
    logic [CNTWIDTH-1:0] cnt_a_p1;
    logic [CNTWIDTH-1:0] cnt_b_p1;

    function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
        if (&v)
            return v;
        return v + 1'b1;
    endfunction

    // ---- stage 1: grant statistics ----
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_a_p1 <= '0;
            cnt_b_p1 <= '0;
        end else begin
            if (a_xfer)
                cnt_a_p1 <= sat_inc(cnt_a_p1);
            if (b_xfer)
                cnt_b_p1 <= sat_inc(cnt_b_p1);
        end
    end

    assign grant_a_cnt = cnt_a_p1;
    assign grant_b_cnt = cnt_b_p1;
`else
    // Counter width only matters with statistics enabled; keep it referenced.
    logic unused_cntwidth;
    assign unused_cntwidth = (CNTWIDTH != 0);
`endif

endmodule

// File: doc/smux_arbiter.md
# smux_arbiter

Two-requester round-robin arbiter that shares one signed DATAWIDTH-bit 2:1 select path and output register between source A and source B. Each side uses a valid/ready handshake. The block drives the mux select internally, registers the winning operand, and presents it downstream with a valid/ready handshake. It sits between two producer stages and a single consumer stage in the signed datapath library.

## Interface
- DATAWIDTH, 8, width of the signed data on every channel
- CNTWIDTH, 16, width of the grant counters (used only when SMUX_ARB_STATS_EN is defined)

- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset; one clock, no other reset
- a_data  in  DATAWIDTH signed  operand from source A
- a_valid  in  1  A offers a_data
- a_ready  out  1  A transfer accepted this cycle
- b_data  in  DATAWIDTH signed  operand from source B
- b_valid  in  1  B offers b_data
- b_ready  out  1  B transfer accepted this cycle
- d  out  DATAWIDTH signed  registered selected operand
- d_valid  out  1  d holds an unconsumed operand
- d_ready  in  1  consumer accepts d
- sel  out  1  source of current d: 0=A, 1=B
- grant_a_cnt, grant_b_cnt  out  CNTWIDTH  accepted transfers per source (SMUX_ARB_STATS_EN only)

## Operation
- A transfer on any channel occurs when valid and ready are both high at a rising Clk.
- Output register states:
  - EMPTY: d_valid=0.
  - FULL: d_valid=1.
- load_en = !d_valid || d_ready. The register can load in the same cycle it is drained.
- Arbitration uses a one-bit pointer `last`, the source of the most recent input transfer.
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the source != last.
  - Neither valid: no grant.
- a_ready = load_en && grant_A. b_ready = load_en && grant_B. At most one ready is high per cycle.
  - Both readys are combinational from the valids and d_ready.
- On an input transfer:
  - d takes the granted data, unmodified in sign and width.
  - sel takes the granted source.
  - d_valid becomes 1.
  - last takes the granted source.
- On d_ready with d_valid and no input transfer: d_valid becomes 0. d and sel hold their last values.
- When d_valid=1 and d_ready=0: d, sel and last are frozen, and both readys are 0.
- Source protocol: once a source raises valid, it holds valid and keeps data stable until its ready is seen. The block does not check this rule.

## Timing
- Reset values while Rst=0:
  - d=0, d_valid=0, sel=0.
  - last=1, so A wins the first tie.
  - Both counters = 0.
  - Readys follow their equations, so they are low whenever the valids are low.
- Latency: an input transfer at edge N produces d_valid=1 with the new d after edge N.
- Throughput: one operand per cycle when d_ready is held high.
- Under continuous contention the grants alternate A, B, A, B, …
- Reset mid-operation: a pending operand in d is discarded and the arbiter restarts with A priority.

## Configuration
- SMUX_ARB_STATS_EN defined:
  - Adds grant_a_cnt and grant_b_cnt.
  - Each counter increments by 1 on every transfer from its source.
  - Each counter saturates at all-ones and does not wrap.
  - Both counters reset to 0.
- SMUX_ARB_STATS_EN undefined:
  - The counter ports and logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then a_valid=1 with a_data=-5 and b_valid=0, d_ready=1 → a_ready=1 in that cycle; next cycle d=-5, sel=0, d_valid=1.
- Both valid every cycle with distinct values (A=+3, B=-7), d_ready=1 → first grant A, then strict alternation, d sequence 3,-7,3,-7, sel 0,1,0,1.
- Load d=-128 (DATAWIDTH=8), then hold d_ready=0 for 4 cycles with both sources valid → a_ready=b_ready=0, d=-128 and sel stable; on d_ready=1 the next source (B) is accepted the same cycle.
- Assert Rst=0 while d_valid=1 and last=A → d=0, d_valid=0, sel=0 immediately; after release, a tie grants A.
- With SMUX_ARB_STATS_EN and CNTWIDTH=2, perform 5 A transfers and 1 B transfer → grant_a_cnt=3 (saturated), grant_b_cnt=1.
